// File: rtl/memcard_pkg.sv
// Shared definitions for the memory card host controller: bus widths,
// default card timing, FSM encoding and the card strobe bundle.
package memcard_pkg;

    localparam int MC_ADDR_W = 24;
    localparam int MC_DATA_W = 8;
    localparam int MC_SIZE   = 2048;
    localparam int MC_CNT_W  = 4;
    localparam int MC_DB_W   = 8;

    localparam int MC_SETUP_CYC_DEF    = 1;
    localparam int MC_STROBE_CYC_DEF   = 3;
    localparam int MC_HOLD_CYC_DEF     = 1;
    localparam int MC_DEBOUNCE_CYC_DEF = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Card-side control pins; all strobes are active low.
    typedef struct packed {
        logic n_ce;
        logic n_oe;
        logic n_we;
        logic n_reg;
        logic cdd_oe;
    } mc_strobes_t;

    localparam mc_strobes_t MC_STROBES_IDLE = '{n_ce: 1'b1, n_oe: 1'b1, n_we: 1'b1,
                                                n_reg: 1'b1, cdd_oe: 1'b0};

    // Phase counters count down to zero, so a phase of N clocks loads N-1.
    function automatic logic [MC_CNT_W-1:0] mc_phase_load(input int cyc);
        return MC_CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/memcard_detect.sv
// Card detect / write-protect front end: two-flop synchronisers on the
// asynchronous slot pins plus an insertion debounce counter.
module memcard_detect
    import memcard_pkg::*;
#(
    parameter int DEBOUNCE_CYC = MC_DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic n_cd1,
    input  logic n_cd2,
    input  logic n_wp,
    output logic card_present,
    output logic card_wp
);

    localparam logic [MC_DB_W-1:0] DB_MAX = MC_DB_W'(DEBOUNCE_CYC);

    logic [1:0]         cd1_sync_q, cd1_sync_d;
    logic [1:0]         cd2_sync_q, cd2_sync_d;
    logic [1:0]         wp_sync_q,  wp_sync_d;
    logic [MC_DB_W-1:0] db_cnt_q,   db_cnt_d;
    logic               both_low;

    assign both_low = ~cd1_sync_q[1] & ~cd2_sync_q[1];

    always_comb begin
        cd1_sync_d = {cd1_sync_q[0], n_cd1};
        cd2_sync_d = {cd2_sync_q[0], n_cd2};
        wp_sync_d  = {wp_sync_q[0], n_wp};
        if (!both_low) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_MAX) begin
            db_cnt_d = db_cnt_q;
        end else begin
            db_cnt_d = db_cnt_q + MC_DB_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd1_sync_q <= 2'b11;
            cd2_sync_q <= 2'b11;
            wp_sync_q  <= 2'b00;
            db_cnt_q   <= '0;
        end else begin
            cd1_sync_q <= cd1_sync_d;
            cd2_sync_q <= cd2_sync_d;
            wp_sync_q  <= wp_sync_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    // Gating with the live synced lines makes removal visible at once,
    // one clock before the counter itself clears.
    assign card_present = both_low && (db_cnt_q == DB_MAX);
    assign card_wp      = ~wp_sync_q[1];

endmodule

// File: rtl/memcard_ctrl.sv
// Host-side memory card initiator: turns single-cycle REQ/ACK requests into
// timed setup/strobe/hold card bus cycles, refusing absent or protected cards.
module memcard_ctrl
    import memcard_pkg::*;
#(
    parameter int SETUP_CYC    = MC_SETUP_CYC_DEF,
    parameter int STROBE_CYC   = MC_STROBE_CYC_DEF,
    parameter int HOLD_CYC     = MC_HOLD_CYC_DEF,
    parameter int DEBOUNCE_CYC = MC_DEBOUNCE_CYC_DEF
) (
    input  logic                 CLK_24M,
    input  logic                 RESET,
    input  logic                 REQ,
    input  logic                 WE,
    input  logic                 REG_SEL,
    input  logic [MC_ADDR_W-1:0] ADDR,
    input  logic [MC_DATA_W-1:0] WDATA,
    output logic [MC_DATA_W-1:0] RDATA,
    output logic                 ACK,
    output logic                 ERR,
    output logic                 BUSY,
    output logic                 CARD_PRESENT,
    output logic                 CARD_WP,
    output logic [MC_ADDR_W-1:0] CDA,
    output logic [MC_DATA_W-1:0] CDD_O,
    output logic                 CDD_OE,
    input  logic [MC_DATA_W-1:0] CDD_I,
    output logic                 nCE,
    output logic                 nOE,
    output logic                 nWE,
    output logic                 nREG,
    input  logic                 nCD1,
    input  logic                 nCD2,
    input  logic                 nWP
);

    localparam logic [MC_CNT_W-1:0] SETUP_LD  = mc_phase_load(SETUP_CYC);
    localparam logic [MC_CNT_W-1:0] STROBE_LD = mc_phase_load(STROBE_CYC);
    localparam logic [MC_CNT_W-1:0] HOLD_LD   = mc_phase_load(HOLD_CYC);

    logic                 card_present;
    logic                 card_wp;

    logic [2:0]           state_q, state_d;
    logic [MC_CNT_W-1:0]  cnt_q,   cnt_d;
    logic                 we_q,    we_d;
    logic                 abort_q, abort_d;
    mc_strobes_t          strb_q,  strb_d;
    logic [MC_ADDR_W-1:0] cda_q,   cda_d;
    logic [MC_DATA_W-1:0] cdd_o_q, cdd_o_d;
    logic [MC_DATA_W-1:0] rdata_q, rdata_d;
    logic                 ack_q,   ack_d;
    logic                 err_q,   err_d;
    logic                 busy_q,  busy_d;

    memcard_detect #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_detect (
        .clk          (CLK_24M),
        .rst          (RESET),
        .n_cd1        (nCD1),
        .n_cd2        (nCD2),
        .n_wp         (nWP),
        .card_present (card_present),
        .card_wp      (card_wp)
    );

    always_comb begin
        // NOTE: every variable gets a default before the case statement;
        // a path that leaves one unassigned would infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        abort_d = abort_q;
        strb_d  = strb_q;
        cda_d   = cda_q;
        cdd_o_d = cdd_o_q;
        rdata_d = rdata_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (REQ) begin
                    busy_d  = 1'b1;
                    we_d    = WE;
                    abort_d = 1'b0;
                    if (!card_present || (WE && card_wp)) begin
                        // Refused: the card bus is never touched.
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d      = ST_SETUP;
                        cnt_d        = SETUP_LD;
                        cda_d        = ADDR;
                        strb_d.n_ce  = 1'b0;
                        strb_d.n_reg = ~REG_SEL;
                        if (WE) begin
                            strb_d.cdd_oe = 1'b1;
                            cdd_o_d       = WDATA;
                        end
                    end
                end
            end

            ST_SETUP: begin
                if (!card_present) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    abort_d = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d     = ST_STROBE;
                    cnt_d       = STROBE_LD;
                    strb_d.n_oe = we_q;
                    strb_d.n_we = ~we_q;
                end else begin
                    cnt_d = cnt_q - MC_CNT_W'(1);
                end
            end

            ST_STROBE: begin
                // Removal wins over the final edge so an aborted read never
                // lands in RDATA.
                if (!card_present) begin
                    state_d     = ST_HOLD;
                    cnt_d       = HOLD_LD;
                    abort_d     = 1'b1;
                    strb_d.n_oe = 1'b1;
                    strb_d.n_we = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d     = ST_HOLD;
                    cnt_d       = HOLD_LD;
                    strb_d.n_oe = 1'b1;
                    strb_d.n_we = 1'b1;
                    if (!we_q) begin
                        rdata_d = CDD_I;
                    end
                end else begin
                    cnt_d = cnt_q - MC_CNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d       = ST_DONE;
                    ack_d         = 1'b1;
                    err_d         = abort_q;
                    strb_d.n_ce   = 1'b1;
                    strb_d.n_reg  = 1'b1;
                    strb_d.cdd_oe = 1'b0;
                end else begin
                    cnt_d = cnt_q - MC_CNT_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                strb_d  = MC_STROBES_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Asynchronous reset releases every card strobe without waiting for a clock.
    always_ff @(posedge CLK_24M or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            strb_q  <= MC_STROBES_IDLE;
            cda_q   <= '0;
            cdd_o_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            abort_q <= abort_d;
            strb_q  <= strb_d;
            cda_q   <= cda_d;
            cdd_o_q <= cdd_o_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign RDATA        = rdata_q;
    assign ACK          = ack_q;
    assign ERR          = err_q;
    assign BUSY         = busy_q;
    assign CARD_PRESENT = card_present;
    assign CARD_WP      = card_wp;
    assign CDA          = cda_q;
    assign CDD_O        = cdd_o_q;
    assign CDD_OE       = strb_q.cdd_oe;
    assign nCE          = strb_q.n_ce;
    assign nOE          = strb_q.n_oe;
    assign nWE          = strb_q.n_we;
    assign nREG         = strb_q.n_reg;

endmodule

// File: tb/tb_memcard_ctrl.sv
// Directed bench for memcard_ctrl with a 2 KB card model on the card side
// and continuous bus-protocol monitors.
`timescale 1ns/1ps
module tb_memcard_ctrl;
    import memcard_pkg::*;

    logic        CLK_24M = 1'b0;
    logic        RESET = 1'b0;
    logic        REQ = 1'b0, WE = 1'b0, REG_SEL = 1'b0;
    logic [23:0] ADDR = '0;
    logic [7:0]  WDATA = '0;
    logic [7:0]  RDATA;
    logic        ACK, ERR, BUSY, CARD_PRESENT, CARD_WP;
    logic [23:0] CDA;
    logic [7:0]  CDD_O, CDD_I;
    logic        CDD_OE, nCE, nOE, nWE, nREG;
    logic        nCD1 = 1'b1, nCD2 = 1'b1, nWP = 1'b1;

    logic [7:0]  bank [0:MC_SIZE-1];
    int          checks = 0;
    int          errors = 0;
    logic [23:0] prev_cda = '0;
    logic        prev_nce = 1'b1;

    memcard_ctrl dut (
        .CLK_24M(CLK_24M), .RESET(RESET), .REQ(REQ), .WE(WE), .REG_SEL(REG_SEL),
        .ADDR(ADDR), .WDATA(WDATA), .RDATA(RDATA), .ACK(ACK), .ERR(ERR), .BUSY(BUSY),
        .CARD_PRESENT(CARD_PRESENT), .CARD_WP(CARD_WP), .CDA(CDA), .CDD_O(CDD_O),
        .CDD_OE(CDD_OE), .CDD_I(CDD_I), .nCE(nCE), .nOE(nOE), .nWE(nWE), .nREG(nREG),
        .nCD1(nCD1), .nCD2(nCD2), .nWP(nWP)
    );

    always #21 CLK_24M = ~CLK_24M;

    // Card model: drives data while selected and output-enabled, stores on nWE rise.
    assign CDD_I = (!nCE && !nOE) ? bank[CDA[10:0]] : 8'hEE;

    always @(posedge nWE) begin
        if (nCE === 1'b0 && CDD_OE === 1'b1) bank[CDA[10:0]] = CDD_O;
    end

    always @(negedge CLK_24M) begin
        if (RESET === 1'b0) begin
            checks++;
            if (nOE === 1'b0 && nWE === 1'b0) begin
                errors++; $display("FAIL strobe_overlap: nOE=%b nWE=%b, required not both 0", nOE, nWE);
            end
            checks++;
            if (nCE === 1'b1 && (nOE === 1'b0 || nWE === 1'b0)) begin
                errors++; $display("FAIL strobe_without_ce: nOE=%b nWE=%b with nCE=1, required 1/1", nOE, nWE);
            end
            checks++;
            if (prev_nce === 1'b0 && nCE === 1'b0 && CDA !== prev_cda) begin
                errors++; $display("FAIL cda_while_selected: CDA=%h, required %h", CDA, prev_cda);
            end
        end
        prev_cda = CDA;
        prev_nce = nCE;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Issues one request and samples every clock until ACK (index 1 = clock k+1).
    task automatic run_cycle(input logic we, input logic rs, input logic [23:0] a,
                             input logic [7:0] wd, output int ack_i, output logic err_o,
                             output logic [7:0] rd_o, output int noe_n, output int nwe_n,
                             output int nce_n, output int nreg_n, output int cdd_bad,
                             output logic busy_after);
        @(negedge CLK_24M);
        REQ = 1'b1; WE = we; REG_SEL = rs; ADDR = a; WDATA = wd;
        @(posedge CLK_24M);
        #1 REQ = 1'b0;
        ack_i = 0; err_o = 1'bx; rd_o = 8'hxx;
        noe_n = 0; nwe_n = 0; nce_n = 0; nreg_n = 0; cdd_bad = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK_24M);
            if (nOE === 1'b0) noe_n++;
            if (nWE === 1'b0) nwe_n++;
            if (nCE === 1'b0) nce_n++;
            if (nREG === 1'b0) nreg_n++;
            if (nCE === 1'b0 && we && (CDD_OE !== 1'b1 || CDD_O !== wd)) cdd_bad++;
            if (ACK === 1'b1) begin
                ack_i = i; err_o = ERR; rd_o = RDATA;
                break;
            end
        end
        @(negedge CLK_24M);
        busy_after = BUSY;
    endtask

    task automatic test_reset();
        #1 RESET = 1'b1;
        repeat (3) @(posedge CLK_24M);
        #1;
        checks++; if ({nCE, nOE, nWE, nREG} !== 4'b1111) begin errors++; $display("FAIL reset_strobes: %b, required 1111", {nCE, nOE, nWE, nREG}); end
        checks++; if ({CDD_OE, ACK, ERR, BUSY, CARD_PRESENT} !== 5'b0) begin errors++; $display("FAIL reset_flags: %b, required 00000", {CDD_OE, ACK, ERR, BUSY, CARD_PRESENT}); end
        checks++; if (CDA !== 24'h0 || CDD_O !== 8'h0 || RDATA !== 8'h0) begin errors++; $display("FAIL reset_data: CDA=%h CDD_O=%h RDATA=%h, required 0", CDA, CDD_O, RDATA); end
        checks++; if (CARD_WP !== 1'b1) begin errors++; $display("FAIL reset_wp: %b, required 1", CARD_WP); end
        @(negedge CLK_24M) RESET = 1'b0;
        repeat (4) @(posedge CLK_24M);
        #1;
        checks++; if (CARD_WP !== 1'b0) begin errors++; $display("FAIL wp_sync_release: %b, required 0", CARD_WP); end
        checks++; if (CARD_PRESENT !== 1'b0) begin errors++; $display("FAIL absent_after_reset: %b, required 0", CARD_PRESENT); end
    endtask

    task automatic test_insert_read();
        int present_i, ack_i, noe_n, nwe_n, nce_n, nreg_n, bad;
        logic err, busy;
        logic [7:0] rd;
        @(negedge CLK_24M);
        nCD1 = 1'b0; nCD2 = 1'b0;
        present_i = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK_24M); #1;
            if (CARD_PRESENT === 1'b1) begin present_i = i; break; end
        end
        checks++; if (present_i != 18) begin errors++; $display("FAIL insert_debounce: present after %0d clocks, required 18", present_i); end
        run_cycle(1'b0, 1'b0, 24'h000005, 8'h00, ack_i, err, rd, noe_n, nwe_n, nce_n, nreg_n, bad, busy);
        checks++; if (ack_i != 6) begin errors++; $display("FAIL read_latency: ACK at k+%0d, required k+6", ack_i); end
        checks++; if (rd !== 8'hA5 || err !== 1'b0) begin errors++; $display("FAIL read_data: RDATA=%h ERR=%b, required A5/0", rd, err); end
        checks++; if (noe_n != 3 || nwe_n != 0) begin errors++; $display("FAIL read_strobe: nOE low %0d nWE low %0d, required 3/0", noe_n, nwe_n); end
        checks++; if (nce_n != 5 || nreg_n != 0) begin errors++; $display("FAIL read_ce: nCE low %0d nREG low %0d, required 5/0", nce_n, nreg_n); end
        checks++; if (busy !== 1'b0 || RDATA !== 8'hA5) begin errors++; $display("FAIL read_after: BUSY=%b RDATA=%h, required 0/A5", busy, RDATA); end
    endtask

    task automatic test_write_readback();
        int ack_i, noe_n, nwe_n, nce_n, nreg_n, bad;
        logic err, busy;
        logic [7:0] rd;
        run_cycle(1'b1, 1'b0, 24'h0007FF, 8'h3C, ack_i, err, rd, noe_n, nwe_n, nce_n, nreg_n, bad, busy);
        checks++; if (ack_i != 6 || err !== 1'b0) begin errors++; $display("FAIL write_ack: ACK at k+%0d ERR=%b, required k+6/0", ack_i, err); end
        checks++; if (nwe_n != 3 || noe_n != 0) begin errors++; $display("FAIL write_strobe: nWE low %0d nOE low %0d, required 3/0", nwe_n, noe_n); end
        checks++; if (bad != 0 || nce_n != 5) begin errors++; $display("FAIL write_cdd_stable: %0d bad of %0d selected clocks, required 0 of 5", bad, nce_n); end
        checks++; if (bank[11'h7FF] !== 8'h3C) begin errors++; $display("FAIL write_bank: %h, required 3C", bank[11'h7FF]); end
        checks++; if (CDD_OE !== 1'b0) begin errors++; $display("FAIL write_oe_release: %b, required 0", CDD_OE); end
        run_cycle(1'b0, 1'b1, 24'h0007FF, 8'h00, ack_i, err, rd, noe_n, nwe_n, nce_n, nreg_n, bad, busy);
        checks++; if (ack_i != 6 || rd !== 8'h3C || err !== 1'b0) begin errors++; $display("FAIL readback: k+%0d RDATA=%h ERR=%b, required k+6/3C/0", ack_i, rd, err); end
        checks++; if (nreg_n != 5 || nREG !== 1'b1) begin errors++; $display("FAIL attr_nreg: low %0d now %b, required 5/1", nreg_n, nREG); end
    endtask

    task automatic test_back_to_back();
        int first, second, busy_low;
        logic [7:0] rd2;
        @(negedge CLK_24M);
        REQ = 1'b1; WE = 1'b0; REG_SEL = 1'b0; ADDR = 24'h000005;
        @(posedge CLK_24M);
        first = 0; second = 0; busy_low = 0; rd2 = 8'hxx;
        for (int i = 1; i <= 30; i++) begin
            @(negedge CLK_24M);
            if (ACK === 1'b1 && first == 0) first = i;
            else if (ACK === 1'b1 && second == 0) begin second = i; rd2 = RDATA; end
            if (i <= 13 && BUSY !== 1'b1) busy_low++;
            if (i == 8) REQ = 1'b0;
        end
        checks++; if (first != 6 || second != 13) begin errors++; $display("FAIL b2b_ack: k+%0d and k+%0d, required k+6 and k+13", first, second); end
        checks++; if (busy_low != 1 || rd2 !== 8'hA5) begin errors++; $display("FAIL b2b_gap: idle clocks %0d RDATA=%h, required 1/A5", busy_low, rd2); end
    endtask

    task automatic test_protected();
        int ack_i, noe_n, nwe_n, nce_n, nreg_n, bad;
        logic err, busy;
        logic [7:0] rd;
        @(negedge CLK_24M) nWP = 1'b0;
        repeat (3) @(posedge CLK_24M);
        #1;
        checks++; if (CARD_WP !== 1'b1) begin errors++; $display("FAIL wp_sync: %b, required 1", CARD_WP); end
        run_cycle(1'b1, 1'b0, 24'h000010, 8'h11, ack_i, err, rd, noe_n, nwe_n, nce_n, nreg_n, bad, busy);
        checks++; if (ack_i != 1 || err !== 1'b1) begin errors++; $display("FAIL wp_refuse: k+%0d ERR=%b, required k+1/1", ack_i, err); end
        checks++; if (nce_n != 0 || nwe_n != 0 || busy !== 1'b0) begin errors++; $display("FAIL wp_no_cycle: nCE low %0d nWE low %0d BUSY=%b, required 0/0/0", nce_n, nwe_n, busy); end
        checks++; if (bank[11'h010] !== 8'h77) begin errors++; $display("FAIL wp_bank: %h, required 77", bank[11'h010]); end
        run_cycle(1'b0, 1'b0, 24'h000010, 8'h00, ack_i, err, rd, noe_n, nwe_n, nce_n, nreg_n, bad, busy);
        checks++; if (ack_i != 6 || err !== 1'b0 || rd !== 8'h77) begin errors++; $display("FAIL wp_read: k+%0d ERR=%b RDATA=%h, required k+6/0/77", ack_i, err, rd); end
        @(negedge CLK_24M) nWP = 1'b1;
        repeat (3) @(posedge CLK_24M);
    endtask

    task automatic test_removal();
        int ack_i, rise;
        logic err;
        logic [7:0] rd;
        @(negedge CLK_24M);
        REQ = 1'b1; WE = 1'b0; REG_SEL = 1'b0; ADDR = 24'h000005;
        @(posedge CLK_24M);
        #1 REQ = 1'b0;
        ack_i = 0; rise = 0; err = 1'bx; rd = 8'hxx;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK_24M);
            if (i == 2) begin
                checks++; if (nOE !== 1'b0) begin errors++; $display("FAIL removal_strobe_on: nOE=%b, required 0", nOE); end
                nCD1 = 1'b1;
            end else if (i > 2 && rise == 0 && nOE === 1'b1) begin
                rise = i - 2;
            end
            if (ACK === 1'b1) begin ack_i = i; err = ERR; rd = RDATA; break; end
        end
        checks++; if (rise < 1 || rise > 3) begin errors++; $display("FAIL removal_release: nOE high after %0d clocks, required 1..3", rise); end
        checks++; if (ack_i == 0 || err !== 1'b1) begin errors++; $display("FAIL removal_err: ACK at k+%0d ERR=%b, required ACK with ERR=1", ack_i, err); end
        checks++; if (rd !== 8'h77) begin errors++; $display("FAIL removal_rdata: %h, required 77", rd); end
        checks++; if (CARD_PRESENT !== 1'b0) begin errors++; $display("FAIL removal_present: %b, required 0", CARD_PRESENT); end
    endtask

    task automatic test_absent();
        int ack_i, noe_n, nwe_n, nce_n, nreg_n, bad;
        logic err, busy;
        logic [7:0] rd;
        @(negedge CLK_24M) nCD2 = 1'b1;
        repeat (3) @(posedge CLK_24M);
        run_cycle(1'b0, 1'b0, 24'h000005, 8'h00, ack_i, err, rd, noe_n, nwe_n, nce_n, nreg_n, bad, busy);
        checks++; if (ack_i != 1 || err !== 1'b1) begin errors++; $display("FAIL absent_refuse: k+%0d ERR=%b, required k+1/1", ack_i, err); end
        checks++; if (nce_n + noe_n + nwe_n != 0) begin errors++; $display("FAIL absent_no_strobe: %0d strobe clocks, required 0", nce_n + noe_n + nwe_n); end
    endtask

    task automatic test_reset_mid_setup();
        int present_i, ack_seen;
        @(negedge CLK_24M);
        nCD1 = 1'b0; nCD2 = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK_24M); #1;
            if (CARD_PRESENT === 1'b1) break;
        end
        @(negedge CLK_24M);
        REQ = 1'b1; WE = 1'b1; REG_SEL = 1'b0; ADDR = 24'h000020; WDATA = 8'h5A;
        @(posedge CLK_24M);
        #1 REQ = 1'b0;
        #3;
        checks++; if (nCE !== 1'b0 || CDD_OE !== 1'b1) begin errors++; $display("FAIL setup_entered: nCE=%b CDD_OE=%b, required 0/1", nCE, CDD_OE); end
        RESET = 1'b1;
        #1;
        checks++; if ({nCE, nOE, nWE, CDD_OE} !== 4'b1110) begin errors++; $display("FAIL async_release: %b, required 1110", {nCE, nOE, nWE, CDD_OE}); end
        checks++; if (CARD_PRESENT !== 1'b0) begin errors++; $display("FAIL reset_present: %b, required 0", CARD_PRESENT); end
        ack_seen = 0;
        repeat (2) begin @(posedge CLK_24M); #1; if (ACK !== 1'b0) ack_seen++; end
        @(negedge CLK_24M) RESET = 1'b0;
        present_i = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK_24M); #1;
            if (ACK !== 1'b0) ack_seen++;
            if (CARD_PRESENT === 1'b1 && present_i == 0) present_i = i;
        end
        checks++; if (ack_seen != 0) begin errors++; $display("FAIL reset_no_ack: %0d ACK clocks, required 0", ack_seen); end
        checks++; if (present_i != 18) begin errors++; $display("FAIL redebounce: present after %0d clocks, required 18", present_i); end
        checks++; if (bank[11'h020] !== 8'h00) begin errors++; $display("FAIL reset_bank: %h, required 00", bank[11'h020]); end
    endtask

    initial begin
        for (int i = 0; i < MC_SIZE; i++) bank[i] = 8'h00;
        bank[11'h005] = 8'hA5;
        bank[11'h010] = 8'h77;
        test_reset();
        test_insert_read();
        test_write_readback();
        test_back_to_back();
        test_protected();
        test_removal();
        test_absent();
        test_reset_mid_setup();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
